// File: rtl/coin_acceptor_if.sv
// Coin acceptor signal bundle.
//   coin_raw      : async coin-slot sensor, high while a coin passes
//   coin_denom    : coin value code (00=1, 01=2, 10=5, 11=invalid)
//   cancel        : synchronous user cancel
//   wash_done     : completion level from the wash controller
//   coin_in       : one-cycle start pulse to the wash controller
//   credit        : current accumulated credit
//   coin_reject   : one-cycle pulse per detected-but-not-credited coin
//   refund_valid  : one-cycle pulse qualifying refund_amount
//   refund_amount : units returned, 0 when refund_valid is low
// slave = the acceptor, master = the environment driving it.
interface coin_acceptor_if;
  logic       coin_raw;
  logic [1:0] coin_denom;
  logic       cancel;
  logic       wash_done;
  logic       coin_in;
  logic [3:0] credit;
  logic       coin_reject;
  logic       refund_valid;
  logic [3:0] refund_amount;

  modport slave (
    input  coin_raw, coin_denom, cancel, wash_done,
    output coin_in, credit, coin_reject, refund_valid, refund_amount
  );

  modport master (
    output coin_raw, coin_denom, cancel, wash_done,
    input  coin_in, credit, coin_reject, refund_valid, refund_amount
  );
endinterface

// File: rtl/coin_acceptor.sv
// Coin acceptor for a wash machine: synchronizes and debounces the coin
// sensor, accumulates credit, starts a wash once PRICE is reached, and
// refunds leftover credit on cancel or at the end of the wash.
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : coin_acceptor_if.slave (see interface header for signals)
// A coin event registered after edge N+1+DEB_CYCLES is acted on by the FSM
// at edge N+2+DEB_CYCLES, N being the first edge that samples coin_raw high.
module coin_acceptor #(
  parameter int DEB_CYCLES = 4,
  parameter int PRICE      = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  coin_acceptor_if.slave bus
);

  localparam logic [3:0] DEB_C  = 4'(DEB_CYCLES);
  localparam logic [3:0] DEB_M1 = 4'(DEB_CYCLES - 1);
  localparam logic [3:0] PRICE4 = 4'(PRICE);
  localparam logic [4:0] PRICE5 = 5'(PRICE);

  typedef enum logic [1:0] {IDLE, COLLECT, START, BUSY} state_e;

  state_e     state_q, state_d;
  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic [3:0] cnt_q, cnt_d;
  logic       evt_q, evt_d;
  logic [1:0] denom_q, denom_d;
  logic       wd_q, wd_d;
  logic [3:0] credit_q, credit_d;
  logic       rej_q, rej_d;
  logic       rv_q, rv_d;
  logic [3:0] ra_q, ra_d;

  logic [2:0] coin_val;
  logic [4:0] sum;
  logic       fits;
  logic       wd_rise;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= '0;
      evt_q    <= 1'b0;
      denom_q  <= '0;
      wd_q     <= 1'b0;
      credit_q <= '0;
      rej_q    <= 1'b0;
      rv_q     <= 1'b0;
      ra_q     <= '0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      cnt_q    <= cnt_d;
      evt_q    <= evt_d;
      denom_q  <= denom_d;
      wd_q     <= wd_d;
      credit_q <= credit_d;
      rej_q    <= rej_d;
      rv_q     <= rv_d;
      ra_q     <= ra_d;
    end
  end

  // Synchronizer and debounce. The counter saturates at DEB_CYCLES so a
  // long pulse yields exactly one event; any low sample re-arms it.
  always_comb begin
    sync1_d = bus.coin_raw;
    sync2_d = sync1_q;
    wd_d    = bus.wash_done;
    cnt_d   = cnt_q;
    evt_d   = 1'b0;
    denom_d = denom_q;
    if (!sync2_q) begin
      cnt_d = '0;
    end else if (cnt_q != DEB_C) begin
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == DEB_M1) begin
        evt_d   = 1'b1;
        denom_d = bus.coin_denom;
      end
    end
  end

  always_comb begin
    case (denom_q)
      2'b00:   coin_val = 3'd1;
      2'b01:   coin_val = 3'd2;
      2'b10:   coin_val = 3'd5;
      default: coin_val = 3'd0;
    endcase
  end

  assign sum     = {1'b0, credit_q} + {2'b00, coin_val};
  assign fits    = (denom_q != 2'b11) && (sum <= 5'd15);
  // Edge taken against the registered level: already-high on BUSY entry
  // produces no rise.
  assign wd_rise = bus.wash_done && !wd_q;

  // Next state and credit datapath
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    rej_d    = 1'b0;
    rv_d     = 1'b0;
    ra_d     = '0;
    case (state_q)
      IDLE: begin
        credit_d = '0;
        if (evt_q) begin
          if (fits) begin
            credit_d = sum[3:0];
            state_d  = COLLECT;
          end else begin
            rej_d = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (bus.cancel) begin
          // Cancel wins over a coincident coin; that coin is bounced.
          rv_d     = 1'b1;
          ra_d     = credit_q;
          credit_d = '0;
          rej_d    = evt_q;
          state_d  = IDLE;
        end else begin
          if (evt_q) begin
            if (fits) credit_d = sum[3:0];
            else      rej_d    = 1'b1;
          end
          if ({1'b0, credit_d} >= PRICE5) state_d = START;
        end
      end
      START: begin
        credit_d = credit_q - PRICE4;
        rej_d    = evt_q;
        state_d  = BUSY;
      end
      BUSY: begin
        rej_d = evt_q;
        if (wd_rise) begin
          if (credit_q != 4'd0) begin
            rv_d = 1'b1;
            ra_d = credit_q;
          end
          credit_d = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.coin_in       = (state_q == START);
    bus.credit        = credit_q;
    bus.coin_reject   = rej_q;
    bus.refund_valid  = rv_q;
    bus.refund_amount = ra_q;
  end

endmodule

// File: tb/tb_coin_acceptor.sv
module tb_coin_acceptor;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       coin_raw = 1'b0;
  logic [1:0] coin_denom = 2'b00;
  logic       cancel = 1'b0;
  logic       wash_done = 1'b0;

  always #5 clk = ~clk;

  coin_acceptor_if bus0();
  coin_acceptor_if bus1();

  assign bus0.coin_raw   = coin_raw;
  assign bus0.coin_denom = coin_denom;
  assign bus0.cancel     = cancel;
  assign bus0.wash_done  = wash_done;
  assign bus1.coin_raw   = coin_raw;
  assign bus1.coin_denom = coin_denom;
  assign bus1.cancel     = cancel;
  assign bus1.wash_done  = wash_done;

  coin_acceptor #(.DEB_CYCLES(D), .PRICE(4))  u_lo (.clk(clk), .rst_n(rst_n), .bus(bus0));
  coin_acceptor #(.DEB_CYCLES(D), .PRICE(15)) u_hi (.clk(clk), .rst_n(rst_n), .bus(bus1));

  logic [1:0] cin_w, rej_w, rv_w;
  logic [3:0] cred_w [2];
  logic [3:0] ra_w   [2];
  assign cin_w  = {bus1.coin_in, bus0.coin_in};
  assign rej_w  = {bus1.coin_reject, bus0.coin_reject};
  assign rv_w   = {bus1.refund_valid, bus0.refund_valid};
  assign cred_w[0] = bus0.credit;
  assign cred_w[1] = bus1.credit;
  assign ra_w[0]   = bus0.refund_amount;
  assign ra_w[1]   = bus1.refund_amount;

  int n_chk = 0;
  int n_fail = 0;
  int n_cin[2], n_rej[2], n_ref[2], ref_sum[2], bad_amt[2];
  int m_cred[2], m_busy[2];
  int price[2] = '{4, 15};

  task automatic chk(string tag, int obs, int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int val_of(int code);
    case (code)
      0: return 1;
      1: return 2;
      2: return 5;
      default: return 0;
    endcase
  endfunction

  task automatic clr();
    for (int d = 0; d < 2; d++) begin
      n_cin[d] = 0; n_rej[d] = 0; n_ref[d] = 0; ref_sum[d] = 0; bad_amt[d] = 0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      if (cin_w[d]) n_cin[d]++;
      if (rej_w[d]) n_rej[d]++;
      if (rv_w[d]) begin
        n_ref[d]++;
        ref_sum[d] += int'(ra_w[d]);
      end else if (ra_w[d] != 4'd0) begin
        bad_amt[d]++;
      end
    end
  endtask

  task automatic chk_zero(string tag);
    for (int d = 0; d < 2; d++)
      chk($sformatf("%s_d%0d", tag, d),
          int'({cin_w[d], cred_w[d], rej_w[d], rv_w[d], ra_w[d]}), 0);
  endtask

  task automatic chk_counts(string tag, int d, int e_rej, int e_cin, int e_ref, int e_sum);
    chk($sformatf("%s_rej_d%0d", tag, d), n_rej[d], e_rej);
    chk($sformatf("%s_cin_d%0d", tag, d), n_cin[d], e_cin);
    chk($sformatf("%s_ref_d%0d", tag, d), n_ref[d], e_ref);
    chk($sformatf("%s_refsum_d%0d", tag, d), ref_sum[d], e_sum);
    chk($sformatf("%s_amt0_d%0d", tag, d), bad_amt[d], 0);
    chk($sformatf("%s_credit_d%0d", tag, d), int'(cred_w[d]), m_cred[d]);
  endtask

  // Coin of a given code held for len cycles; optionally a one-cycle cancel
  // landing on the same edge the coin event is acted on.
  task automatic coin(string tag, int code, int len, bit canc);
    int pre[2], post[2], old[2];
    int e_rej, e_cin, e_ref, e_sum, e_post;
    bit evt;
    evt = (len >= D);
    clr();
    old = m_cred;
    coin_raw = 1'b1;
    coin_denom = 2'(code);
    for (int t = 1; t <= len + D + 6; t++) begin
      tick();
      if (t == D + 2) begin
        for (int d = 0; d < 2; d++) pre[d] = int'(cred_w[d]);
        cancel = canc;
      end
      if (t == D + 3) begin
        for (int d = 0; d < 2; d++) post[d] = int'(cred_w[d]);
        cancel = 1'b0;
      end
      if (t == len) coin_raw = 1'b0;
    end
    for (int d = 0; d < 2; d++) begin
      e_rej = 0; e_cin = 0; e_ref = 0; e_sum = 0; e_post = old[d];
      if (canc && m_busy[d] == 0 && m_cred[d] > 0) begin
        e_ref = 1; e_sum = m_cred[d]; m_cred[d] = 0; e_post = 0; e_rej = int'(evt);
      end else if (evt) begin
        if (m_busy[d] != 0 || code == 3 || m_cred[d] + val_of(code) > 15) begin
          e_rej = 1;
        end else begin
          m_cred[d] += val_of(code);
          e_post = m_cred[d];
          if (m_cred[d] >= price[d]) begin
            e_cin = 1; m_cred[d] -= price[d]; m_busy[d] = 1;
          end
        end
      end
      chk($sformatf("%s_pre_d%0d", tag, d), pre[d], old[d]);
      chk($sformatf("%s_post_d%0d", tag, d), post[d], e_post);
      chk_counts(tag, d, e_rej, e_cin, e_ref, e_sum);
    end
  endtask

  task automatic do_cancel(string tag);
    int e_ref[2], e_sum[2];
    clr();
    for (int d = 0; d < 2; d++) begin
      e_ref[d] = 0; e_sum[d] = 0;
      if (m_busy[d] == 0 && m_cred[d] > 0) begin
        e_ref[d] = 1; e_sum[d] = m_cred[d]; m_cred[d] = 0;
      end
    end
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    repeat (3) tick();
    for (int d = 0; d < 2; d++) chk_counts(tag, d, 0, 0, e_ref[d], e_sum[d]);
  endtask

  task automatic wash(string tag);
    int e_ref[2], e_sum[2];
    clr();
    for (int d = 0; d < 2; d++) begin
      e_ref[d] = 0; e_sum[d] = 0;
      if (m_busy[d] != 0) begin
        if (m_cred[d] > 0) begin e_ref[d] = 1; e_sum[d] = m_cred[d]; end
        m_cred[d] = 0; m_busy[d] = 0;
      end
    end
    wash_done = 1'b0;
    repeat (2) tick();
    wash_done = 1'b1;
    repeat (3) tick();
    wash_done = 1'b0;
    repeat (2) tick();
    for (int d = 0; d < 2; d++) chk_counts(tag, d, 0, 0, e_ref[d], e_sum[d]);
  endtask

  task automatic do_reset(string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk_zero({tag, "_async"});
    clr();
    for (int d = 0; d < 2; d++) begin m_cred[d] = 0; m_busy[d] = 0; end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    for (int d = 0; d < 2; d++) chk_counts(tag, d, 0, 0, 0, 0);
  endtask

  initial begin
    int op, code, len;
    for (int d = 0; d < 2; d++) begin m_cred[d] = 0; m_busy[d] = 0; end
    clr();

    // Reset state
    #3;
    chk_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) tick();

    // Two coins of 2 reach PRICE=4: start pulse, credit back to 0
    coin("c2a", 1, D + 2, 1'b0);
    coin("c2b", 1, D + 2, 1'b0);
    wash("wash1");
    do_cancel("cancel1");

    // Glitch one cycle short of the debounce
    coin("glitch", 2, D - 1, 1'b0);

    // Coin 5 leaves 1 unit, refunded at end of wash
    coin("c5", 2, D + 2, 1'b0);
    wash("wash2");

    // Cancel coinciding with a second coin
    coin("c2c", 1, D + 2, 1'b0);
    coin("c2cancel", 1, D + 2, 1'b1);

    // Invalid code, then overflow at credit 12
    coin("inval", 3, D + 2, 1'b0);
    coin("c5x", 2, D + 3, 1'b0);
    coin("c5y", 2, D + 2, 1'b0);
    coin("c2y", 1, D + 2, 1'b0);
    coin("ovf", 2, D + 2, 1'b0);
    wash("wash3");
    do_cancel("cancel2");

    // wash_done already high on entry to BUSY must not end the wash
    wash_done = 1'b1;
    coin("wdhigh", 2, D + 2, 1'b0);
    wash("wash4");

    // Reset during BUSY with credit 3
    coin("r2", 1, D + 2, 1'b0);
    coin("r5", 2, D + 2, 1'b0);
    do_reset("rst_busy");
    coin("after_rst", 0, D, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 9));
      if (op <= 6) begin
        code = int'($urandom_range(0, 3));
        len  = ($urandom_range(0, 5) == 0) ? D - 1 : int'($urandom_range(D, D + 4));
        coin($sformatf("rnd%0d_coin", i), code, len, $urandom_range(0, 3) == 0);
      end else if (op == 7) begin
        do_cancel($sformatf("rnd%0d_cancel", i));
      end else begin
        wash($sformatf("rnd%0d_wash", i));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/coin_acceptor.md
COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 4: consecutive synchronized-high cycles needed to accept a coin (range 1..15).
REQ-002 SHALL have parameter PRICE, default 4: credit units per wash cycle (range 1..15).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port coin_raw, input, 1 bit: asynchronous coin-slot sensor, high while a coin passes.
REQ-006 SHALL have port coin_denom, input, 2 bits: coin value code (00=1, 01=2, 10=5, 11=invalid), stable while coin_raw is high.
REQ-007 SHALL have port cancel, input, 1 bit: synchronous user cancel request.
REQ-008 SHALL have port wash_done, input, 1 bit: completion level from the wash controller.
REQ-009 SHALL have port coin_in, output, 1 bit: one-cycle start pulse to the wash controller.
REQ-010 SHALL have port credit, output, 4 bits: current accumulated credit.
REQ-011 SHALL have port coin_reject, output, 1 bit: one-cycle pulse when a detected coin is not credited.
REQ-012 SHALL have port refund_valid, output, 1 bit: one-cycle pulse qualifying refund_amount.
REQ-013 SHALL have port refund_amount, output, 4 bits: units returned; 0 when refund_valid is low.

Function
REQ-014 SHALL synchronize coin_raw through two flip-flops before any use.
REQ-015 SHALL raise one internal coin event after DEB_CYCLES consecutive synchronized-high samples, at most one event per high pulse; the counter clears on any low sample.
REQ-016 SHALL sample coin_denom on the coin-event cycle.
REQ-017 SHALL update credit at clock edge N+2+DEB_CYCLES after a coin is accepted, where N is the first edge at which coin_raw is sampled high.
REQ-018 SHALL implement states IDLE, COLLECT, START and BUSY.
REQ-019 IDLE: credit=0; an accepted coin loads its value into credit and moves to COLLECT.
REQ-020 COLLECT: each accepted coin adds its value; when credit>=PRICE the FSM moves to START.
REQ-021 START: SHALL assert coin_in for exactly one cycle, set credit=credit-PRICE in the same cycle, and move to BUSY.
REQ-022 BUSY: SHALL reject every coin event; on a wash_done rising edge, if credit>0 SHALL pulse refund_valid with refund_amount=credit and clear credit; SHALL then return to IDLE.
REQ-023 SHALL reject a coin event with coin_denom=11, and any coin event whose addition would exceed 15; credit SHALL remain unchanged in both cases.
REQ-024 SHALL, on cancel in COLLECT, pulse refund_valid with refund_amount=credit, clear credit, and go to IDLE; cancel in IDLE, START or BUSY SHALL be ignored.
REQ-025 SHALL, when cancel and a coin event coincide in COLLECT, give cancel priority and reject the coin (coin_reject pulse); the refund excludes that coin.
REQ-026 SHALL detect the wash_done edge from a registered copy, so a wash_done level already high on BUSY entry causes no exit.
REQ-027 SHALL assert coin_reject for one cycle per rejected event; rejected coins SHALL never change credit.

Reset
REQ-028 SHALL on rst_n low immediately set: state=IDLE, credit=0, coin_in=0, coin_reject=0, refund_valid=0, refund_amount=0, synchronizers=0, debounce counter=0, wash_done history=0.
REQ-029 SHALL discard credit on reset mid-operation, with no refund pulse.
REQ-030 SHALL accept the first coin after rst_n deasserts only on a full debounce from synchronized-low.

Verification
REQ-031 Coin pulses of 2, then 2, with PRICE=4 -> credit 2 then 4, one coin_in pulse, credit=0, state BUSY.
REQ-032 A coin_raw glitch of DEB_CYCLES-1 cycles -> no event, credit unchanged, no coin_reject.
REQ-033 Coin 5 with PRICE=4 -> coin_in pulse, credit=1; wash_done rising -> refund_valid with refund_amount=1, state IDLE.
REQ-034 Coin 2, then cancel coinciding with a second coin event -> refund_amount=2, coin_reject pulse, credit=0.
REQ-035 Coin code 11, and a coin 5 while credit=12 -> two coin_reject pulses, credit unchanged.
REQ-036 rst_n low during BUSY with credit=3 -> all outputs 0, no refund, IDLE after release.
